// File: rtl/sweep_if.sv
// sweep_if: bundle between the sweep sequencer, sweep_ctrl and the counter.
//
// Handshake: start is a request level; sweep_ctrl samples it only while
// busy=0, and an accepted request raises busy on the next edge. busy stays
// high until the run ends (done pulse) or is aborted by stop. A rejected
// request (lo >= hi) leaves busy low and pulses err for one cycle. stop
// overrides start in the same cycle.
//
// Signals:
//   start, stop          request / abort from the sequencer
//   lo, hi, n_sweeps     run parameters, latched when a start is accepted
//   count                feedback from the counter's count output
//   load, u_d, data      drive to the counter (u_d=1 counts up)
//   busy, done, err      registered status
//   sweep_cnt            completed sweeps in the current or last run
interface sweep_if #(
    parameter int WIDTH = 8,
    parameter int NW    = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [NW-1:0]    n_sweeps;
    logic [WIDTH-1:0] count;
    logic             load;
    logic             u_d;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic             err;
    logic [NW-1:0]    sweep_cnt;

    modport master (
        output start, stop, lo, hi, n_sweeps, count,
        input  load, u_d, data, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, stop, lo, hi, n_sweeps, count,
        output load, u_d, data, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives an 8-bit loadable up/down counter through a triangle
// sweep lo -> hi -> lo for a programmed number of sweeps, then holds it.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous, active-low reset
//   bus        sweep_if slave modport (request, limits, counter drive, status)
//   state_dbg  current FSM state (0=IDLE, 1=UP, 2=DOWN)
//
// load/u_d/data are combinational from state, count and start/stop so the
// counter reacts on the very edge the decision is made; all status outputs
// are registered.
module sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int NW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    sweep_if.slave     bus,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_l;
    logic [WIDTH-1:0] hi_l;
    logic [NW-1:0]    n_l;
    logic [NW-1:0]    sweep_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             start_ok;
    logic             at_hi;
    logic             at_lo;
    logic             last_sweep;
    logic [NW-1:0]    cnt_inc;

    logic             load_c;
    logic             u_d_c;
    logic [WIDTH-1:0] data_c;

    assign start_ok   = bus.start && !bus.stop && (bus.lo < bus.hi);
    assign at_hi      = (bus.count == hi_l);
    assign at_lo      = (bus.count == lo_l);
    assign cnt_inc    = sweep_cnt_r + NW'(1);
    // n_l == 0 selects continuous mode, where no sweep is ever the last.
    assign last_sweep = (n_l != '0) && (cnt_inc == n_l);

    // Default is "hold": reload the counter with its own value.
    always_comb begin
        load_c = 1'b1;
        u_d_c  = 1'b1;
        data_c = bus.count;
        if (!rst) begin
            data_c = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) data_c = bus.lo;
                end
                UP: begin
                    if (!bus.stop) begin
                        load_c = 1'b0;
                        // Turn around on the cycle count sits at hi, so hi
                        // is seen for exactly one cycle.
                        u_d_c  = !at_hi;
                    end
                end
                DOWN: begin
                    if (!bus.stop && !(at_lo && last_sweep)) begin
                        load_c = 1'b0;
                        u_d_c  = at_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lo_l        <= '0;
            hi_l        <= '0;
            n_l         <= '0;
            sweep_cnt_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.lo < bus.hi) begin
                            lo_l        <= bus.lo;
                            hi_l        <= bus.hi;
                            n_l         <= bus.n_sweeps;
                            sweep_cnt_r <= '0;
                            state       <= UP;
                            busy_r      <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (at_hi) begin
                        state <= DOWN;
                    end
                end
                DOWN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (at_lo) begin
                        // Wraps freely in continuous mode.
                        sweep_cnt_r <= cnt_inc;
                        if (last_sweep) begin
                            done_r <= 1'b1;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state <= UP;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load      = load_c;
    assign bus.u_d       = u_d_c;
    assign bus.data      = data_c;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.sweep_cnt = sweep_cnt_r;
    assign state_dbg     = state;

endmodule
